// File: rtl/mprjram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the user-project memory window.
// Define MPRJRAM_ARB_TIMEOUT_EN to add a watchdog that aborts unacknowledged cycles with err.
module mprjram_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADR_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADR_W-1:0]    m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADR_W-1:0]    m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,

  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADR_W-1:0]    s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,

  output logic [1:0]          gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     r_state, w_state_next;
  logic [1:0] r_gnt, w_gnt_next;
  logic       r_last, w_last_next;   // 1: m1 was served last
  logic       w_req0, w_req1;
  logic       w_busy, w_own1;
  logic       w_own_cyc, w_own_stb;
  logic       w_tmo_hit;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_own1    = r_gnt[1];
  assign w_own_cyc = w_own1 ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = w_own1 ? m1_stb_i : m0_stb_i;
  assign gnt_o     = r_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_last_next  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_state_next = ST_BUSY;
          if (w_req0 & w_req1)
            w_gnt_next = r_last ? 2'b01 : 2'b10;
          else
            w_gnt_next = w_req0 ? 2'b01 : 2'b10;
        end
      end
      ST_BUSY: begin
        // Completion (ack, or watchdog) advances fairness; an abort does not.
        if (s_ack_i | w_tmo_hit) begin
          w_state_next = ST_RELEASE;
          w_gnt_next   = 2'b00;
          w_last_next  = w_own1;
        end else if (!w_own_cyc) begin
          w_state_next = ST_RELEASE;
          w_gnt_next   = 2'b00;
        end
      end
      ST_RELEASE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = 2'b00;
      end
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (w_busy) begin
      s_cyc_o  = w_own_cyc & w_own_stb & ~w_tmo_hit;
      s_stb_o  = w_own_cyc & w_own_stb & ~w_tmo_hit;
      s_we_o   = w_own1 ? m1_we_i  : m0_we_i;
      s_sel_o  = w_own1 ? m1_sel_i : m0_sel_i;
      s_adr_o  = w_own1 ? m1_adr_i : m0_adr_i;
      s_dat_o  = w_own1 ? m1_dat_i : m0_dat_i;
      m0_ack_o = r_gnt[0] & s_ack_i;
      m1_ack_o = r_gnt[1] & s_ack_i;
      if (r_gnt[0]) m0_dat_o = s_dat_i;
      if (r_gnt[1]) m1_dat_o = s_dat_i;
    end
  end

`ifdef MPRJRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_tmo_cnt;

  // Cleared outside BUSY so every grant starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo_cnt <= '0;
    else if (!w_busy)
      r_tmo_cnt <= '0;
    else if (!s_ack_i && !w_tmo_hit)
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
  end

  assign w_tmo_hit = w_busy & (r_tmo_cnt == TMO_LIMIT);
  assign m0_err_o  = w_tmo_hit & ~s_ack_i & r_gnt[0];
  assign m1_err_o  = w_tmo_hit & ~s_ack_i & r_gnt[1];
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_tmo_hit = 1'b0;
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mprjram_wb_arbiter.sv
// Directed and randomized checks of mprjram_wb_arbiter against a transaction-level schedule model.
// Runs the watchdog scenario with TIMEOUT=8 when MPRJRAM_ARB_TIMEOUT_EN is defined.
module tb_mprjram_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0]  gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Random-phase model: owner and the cycle numbers at which the arbiter is free / forwarding.
  int          owner, busy_from, free_at, last, sl_cnt, sl_dly;
  bit          busy_now;
  bit          rq[2], seen[2];
  logic        rwe[2];
  logic [31:0] radr[2], rdat[2];
  logic [3:0]  rsel[2];
  int          done[2];
  logic [1:0]  exp_gnt;

  mprjram_wb_arbiter #(.DATA_W(32), .ADR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int m, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".gnt"}, 32'(gnt_o), 32'd0);
    chk({tag, ".s_cyc"}, 32'(s_cyc_o), 32'd0);
    chk({tag, ".s_stb"}, 32'(s_stb_o), 32'd0);
    chk({tag, ".m0_ack"}, 32'(m0_ack_o), 32'd0);
    chk({tag, ".m1_ack"}, 32'(m1_ack_o), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag);
    chk({tag, ".s_we"}, 32'(s_we_o), 32'd0);
    chk({tag, ".s_sel"}, 32'(s_sel_o), 32'd0);
    chk({tag, ".s_adr"}, s_adr_o, 32'd0);
    chk({tag, ".s_dat"}, s_dat_o, 32'd0);
    chk({tag, ".m0_dat"}, m0_dat_o, 32'd0);
    chk({tag, ".m1_dat"}, m1_dat_o, 32'd0);
    chk({tag, ".m0_err"}, 32'(m0_err_o), 32'd0);
    chk({tag, ".m1_err"}, 32'(m1_err_o), 32'd0);
  endtask

  task automatic new_req(input int m, input bit cont);
    rq[m]   = 1'b1;
    rwe[m]  = cont ? 1'b1 : 1'($urandom_range(0, 1));
    radr[m] = 32'h3800_0000 | ($urandom & 32'h0000_FFFC);
    rdat[m] = cont ? (m == 0 ? 32'h1111_1111 : 32'h2222_2222) : $urandom;
    rsel[m] = 4'($urandom_range(1, 15));
  endtask

  initial begin
    rst_n = 1'b0; s_ack_i = 1'b0; s_dat_i = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with m0 already requesting: nothing forwarded.
    drive(0, 1'b1, 1'b0, 32'h3800_0010, 32'h0, 4'hF);
    settle();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single read, 1-cycle ack slave.
    step(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; settle();
    chk("rd.s_stb", 32'(s_stb_o), 32'd1);
    chk("rd.s_adr", s_adr_o, 32'h3800_0010);
    chk("rd.gnt", 32'(gnt_o), 32'd1);
    chk("rd.m0_ack", 32'(m0_ack_o), 32'd1);
    chk("rd.m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("rd.m1_dat", m1_dat_o, 32'd0);
    step(); s_ack_i = 1'b0; drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk_quiet("rd.release");

    // Stray ack while idle is ignored; the next request is then granted normally.
    step(); s_ack_i = 1'b1; settle();
    chk_quiet("stray");
    step(); s_ack_i = 1'b0; drive(0, 1'b1, 1'b1, 32'h3800_0014, 32'h1111_1111, 4'hF); settle();
    chk("wr.idle_stb", 32'(s_stb_o), 32'd0);
    step(); s_ack_i = 1'b1; settle();
    chk("wr.gnt", 32'(gnt_o), 32'd1);
    chk("wr.s_we", 32'(s_we_o), 32'd1);
    chk("wr.s_dat", s_dat_o, 32'h1111_1111);
    chk("wr.m0_ack", 32'(m0_ack_o), 32'd1);
    step(); s_ack_i = 1'b0; drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk_quiet("wr.release");

    // m0 served last, tie goes to m1, which then aborts.
    step();
    drive(0, 1'b1, 1'b1, 32'h3800_0018, 32'h1111_1111, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h3800_0020, 32'h2222_2222, 4'hF);
    settle();
    chk("tie.idle_gnt", 32'(gnt_o), 32'd0);
    step(); settle();
    chk("tie.gnt", 32'(gnt_o), 32'd2);
    chk("tie.s_adr", s_adr_o, 32'h3800_0020);
    step(); settle();
    chk("abort.busy2_cyc", 32'(s_cyc_o), 32'd1);
    step(); drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk("abort.s_cyc", 32'(s_cyc_o), 32'd0);
    chk("abort.m1_ack", 32'(m1_ack_o), 32'd0);
    chk("abort.m1_err", 32'(m1_err_o), 32'd0);
    step(); drive(1, 1'b1, 1'b0, 32'h3800_0024, 32'h2222_2222, 4'hF); settle();
    chk_quiet("abort.release");
    step(); settle();
    chk_quiet("abort.idle");
    step(); s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D; settle();
    chk("abort.regrant", 32'(gnt_o), 32'd2);
    chk("abort.m1_ack", 32'(m1_ack_o), 32'd1);
    chk("abort.m1_dat", m1_dat_o, 32'hCAFE_F00D);
    chk("abort.m0_dat", m0_dat_o, 32'd0);
    step(); s_ack_i = 1'b0; drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk_quiet("m1.release");

    // Silent slave: m0 granted, m1 pending.
    step(); settle();
    chk("tmo.idle_gnt", 32'(gnt_o), 32'd0);
    step(); drive(1, 1'b1, 1'b0, 32'h3800_002C, 32'h0, 4'hF); settle();
`ifdef MPRJRAM_ARB_TIMEOUT_EN
    for (int b = 1; b <= 8; b++) begin
      chk("tmo.gnt", 32'(gnt_o), 32'd1);
      chk("tmo.s_cyc", 32'(s_cyc_o), 32'd1);
      chk("tmo.err_early", 32'(m0_err_o), 32'd0);
      step(); settle();
    end
    chk("tmo.err", 32'(m0_err_o), 32'd1);
    chk("tmo.s_cyc_drop", 32'(s_cyc_o), 32'd0);
    chk("tmo.m1_err", 32'(m1_err_o), 32'd0);
    step(); drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk_quiet("tmo.release");
    chk("tmo.err_pulse", 32'(m0_err_o), 32'd0);
`else
    for (int b = 1; b <= 20; b++) begin
      chk("hold.gnt", 32'(gnt_o), 32'd1);
      chk("hold.s_cyc", 32'(s_cyc_o), 32'd1);
      chk("hold.err", 32'(m0_err_o), 32'd0);
      step(); settle();
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk("hold.abort_cyc", 32'(s_cyc_o), 32'd0);
    chk("hold.abort_ack", 32'(m0_ack_o), 32'd0);
    step(); settle();
    chk_quiet("hold.release");
`endif
    step(); settle();
    chk("pend.idle_gnt", 32'(gnt_o), 32'd0);
    step(); s_ack_i = 1'b1; s_dat_i = 32'h0BAD_F00D; settle();
    chk("pend.gnt", 32'(gnt_o), 32'd2);
    chk("pend.m1_ack", 32'(m1_ack_o), 32'd1);
    step(); s_ack_i = 1'b0; drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();

    // Asynchronous reset in the middle of a busy cycle.
    step(); drive(0, 1'b1, 1'b0, 32'h3800_0030, 32'h0, 4'hF); settle();
    step(); s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; settle();
    chk("arst.pre_ack", 32'(m0_ack_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("arst");
    s_ack_i = 1'b0;
    step(); rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h3800_0034, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h3800_0038, 32'h0, 4'hF);
    settle();
    chk("arst.idle_gnt", 32'(gnt_o), 32'd0);
    step(); settle();
    chk("arst.tie_gnt", 32'(gnt_o), 32'd1);

    // Randomized traffic, first 60 cycles continuous writes from both masters.
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step(); rst_n = 1'b1;
    owner = -1; busy_from = 0; free_at = 0; last = 1; sl_cnt = 0; sl_dly = 0;
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; seen[m] = 1'b0; done[m] = 0;
    end
    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (seen[m]) begin
          seen[m] = 1'b0;
          if (k >= 60 && $urandom_range(0, 3) == 0) rq[m] = 1'b0;
          else new_req(m, k < 60);
        end else if (!rq[m] && (k < 60 || $urandom_range(0, 2) == 0)) begin
          new_req(m, k < 60);
        end
        drive(m, rq[m], rwe[m], radr[m], rdat[m], rsel[m]);
      end
      settle();
      busy_now = (owner >= 0) && (k >= busy_from);
      if (owner < 0 && k >= free_at) begin
        if (rq[0] && rq[1]) owner = 1 - last;
        else if (rq[0])     owner = 0;
        else if (rq[1])     owner = 1;
        busy_from = k + 1;
      end
      if (s_stb_o) begin
        if (sl_cnt >= sl_dly) begin
          s_ack_i = 1'b1; sl_cnt = 0; sl_dly = $urandom_range(0, 2);
        end else begin
          s_ack_i = 1'b0; sl_cnt++;
        end
      end else begin
        s_ack_i = ($urandom_range(0, 3) == 0);
        sl_cnt = 0;
      end
      s_dat_i = $urandom;
      settle();
      exp_gnt = !busy_now ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
      chk("rnd.gnt", 32'(gnt_o), 32'(exp_gnt));
      chk("rnd.s_cyc", 32'(s_cyc_o), 32'(busy_now));
      chk("rnd.s_stb", 32'(s_stb_o), 32'(busy_now));
      if (busy_now) begin
        chk("rnd.s_adr", s_adr_o, radr[owner]);
        chk("rnd.s_we", 32'(s_we_o), 32'(rwe[owner]));
        chk("rnd.s_sel", 32'(s_sel_o), 32'(rsel[owner]));
        chk("rnd.s_dat", s_dat_o, rdat[owner]);
      end
      chk("rnd.m0_ack", 32'(m0_ack_o), 32'(busy_now && owner == 0 && s_ack_i));
      chk("rnd.m1_ack", 32'(m1_ack_o), 32'(busy_now && owner == 1 && s_ack_i));
      chk("rnd.m0_dat", m0_dat_o, (busy_now && owner == 0) ? s_dat_i : 32'd0);
      chk("rnd.m1_dat", m1_dat_o, (busy_now && owner == 1) ? s_dat_i : 32'd0);
      chk("rnd.m0_err", 32'(m0_err_o), 32'd0);
      chk("rnd.m1_err", 32'(m1_err_o), 32'd0);
      if (busy_now && s_ack_i) begin
        seen[owner] = 1'b1;
        done[owner]++;
        last    = owner;
        owner   = -1;
        free_at = k + 2;
      end
      step();
    end
    chk("rnd.m0_served", 32'(done[0] > 0), 32'd1);
    chk("rnd.m1_served", 32'(done[1] > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mprjram_wb_arbiter.md
# mprjram_wb_arbiter

Two-master Wishbone arbiter that shares the single user-project memory port (SDRAM/BRAM controller window at 0x38000000) between the management SoC bus and a secondary requester such as a prefetch or DMA engine. It grants one master at a time, forwards one classic Wishbone cycle, and returns ack, read data and optional error to the owner. Round-robin fairness prevents either side from starving the other while `matmul()` code executes from that memory. An optional watchdog aborts cycles the downstream controller never acknowledges.

## Interface
- `DATA_W`, 32, data bus width
- `ADR_W`, 32, address width, forwarded unmodified
- `TIMEOUT`, 1023, cycles in BUSY before watchdog abort (watchdog build only)

- `clk` in 1 single clock for all logic
- `rst_n` in 1 reset, asynchronous assert, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 master 0 (SoC) cycle, strobe, write enable
- `m0_sel_i` in DATA_W/8 master 0 byte selects
- `m0_adr_i` in ADR_W master 0 address
- `m0_dat_i` in DATA_W master 0 write data
- `m0_dat_o` out DATA_W read data to master 0
- `m0_ack_o`, `m0_err_o` out 1 ack and error to master 0
- `m1_*` same set as `m0_*`, for master 1 (secondary requester)
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 downstream cycle, strobe, write enable
- `s_sel_o` out DATA_W/8, `s_adr_o` out ADR_W, `s_dat_o` out DATA_W downstream request fields
- `s_dat_i` in DATA_W, `s_ack_i` in 1 downstream read data and ack
- `gnt_o` out 2 one-hot current owner (bit0 = m0), for debug/LA observation

## Operation
- States: IDLE, BUSY, RELEASE.
- Request `reqN = mN_cyc_i & mN_stb_i`.
- IDLE:
  - If only one master requests, grant it.
  - If both request, grant the master not served last. Priority pointer `last` resets to m1, so m0 wins the first tie.
  - Register `gnt_o` and go to BUSY.
- BUSY:
  - Downstream outputs are muxed from the granted master; `s_cyc_o = s_stb_o = granted cyc & stb`.
  - `s_ack_i` passes combinationally to the granted `mN_ack_o`. `s_dat_i` drives the granted `mN_dat_o`; the non-granted `mN_dat_o` is 0.
  - On `s_ack_i`: update `last` to the granted master and go to RELEASE.
  - If the granted master drops `cyc` before ack (abort): go to RELEASE, no ack, `last` unchanged.
- RELEASE:
  - One dead cycle with `s_cyc_o = 0` and `gnt_o = 0`.
  - Go to IDLE. This lets the owner drop `stb` and guarantees the slave sees a `cyc` gap.
- A non-granted master's ack/err stay 0; its request is held pending (Wishbone stall by no-ack).
- The arbiter does no address decode; callers route only the 0x38000000 window here.

## Timing
- Reset values:
  - `gnt_o = 0`, state IDLE, `last = m1`.
  - All `s_*` outputs 0, all `mN_ack_o`/`mN_err_o`/`mN_dat_o` 0.
  - Watchdog count 0.
- Request in cycle n (IDLE) → `s_stb_o` high in cycle n+1.
- Ack is zero-latency through the arbiter (same cycle as `s_ack_i`).
- Back-to-back throughput: minimum 3 cycles per transfer (grant, ack, release) with a 1-cycle-ack slave.
- Simultaneous request in IDLE: resolved in the same cycle by `last`.
- A request arriving in RELEASE waits until IDLE.
- `rst_n` asserted mid-BUSY: all outputs clear immediately (async). The in-flight transfer is dropped with no ack.
- `s_ack_i` while IDLE or RELEASE is ignored.

## Configuration
- `MPRJRAM_ARB_TIMEOUT_EN` defined:
  - A counter (clog2(TIMEOUT+1) bits) clears on grant and increments each BUSY cycle without ack.
  - On reaching `TIMEOUT`: pulse the granted `mN_err_o` for one cycle, force `s_cyc_o`/`s_stb_o` low, go to RELEASE, update `last`.
  - If ack and timeout coincide, ack wins.
- Not defined:
  - No counter; `m0_err_o`/`m1_err_o` tied 0.
  - BUSY persists until ack or abort.

## Test plan
- After reset, m0 reads 0x38000010 while the slave returns 0xDEADBEEF with a 1-cycle ack → `s_stb_o` high 1 cycle after request, `m0_ack_o` for 1 cycle with `m0_dat_o = 0xDEADBEEF`, `gnt_o = 01`, then 1 RELEASE cycle.
- Both masters write continuously (m0 data 0x11111111, m1 data 0x22222222) → the slave sees m0, m1, m0, m1 alternating; no master gets two consecutive grants while the other is pending.
- m1 drops `cyc` 2 cycles into BUSY with no slave ack → no ack or err to m1, RELEASE then IDLE, next tie still granted to m1 (`last` unchanged).
- Timeout build with `TIMEOUT = 8`, slave never acks m0 → `m0_err_o` pulses exactly 8 cycles after grant, `s_cyc_o` drops the same cycle, a pending m1 is granted 2 cycles later. Without the macro, the same stimulus → BUSY held and err stays 0.
- `rst_n` pulsed low mid-BUSY → all outputs 0 asynchronously; after release, a tie grants m0 first.
- Stray `s_ack_i` in IDLE → no `mN_ack_o`, state stays IDLE.
